ifid_queue: RTL and testbench

Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry instruction queue between IF_stage and the decode stage, with a valid/ready push handshake from fetch, a pop/stall interface toward decode, and a single-cycle kill that flushes every entry. Its job is to decouple fetch from decode stalls so IF can run ahead by up to DEPTH instructions, while kill semantics stay identical to the old IF_ID block: the decode stage sees a NOP.

---
 rtl/ifid_queue_pkg.sv | 21 ++
 rtl/ifid_queue_mem.sv | 31 +++
 rtl/ifid_queue.sv | 90 +++++++++
 tb/tb_ifid_queue.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ifid_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue.
//   INSTR_W   : width of an instruction word
//   ADDR_W    : width of the NPC field carried alongside each instruction
//   NOP_WORD  : instruction handed to decode when the queue holds nothing
//   DEPTH_DEF : default number of queue entries
//   cnt_w()   : occupancy counter width for a given depth (must hold 0..depth)
package ifid_queue_pkg;

  localparam int INSTR_W   = 32;
  localparam int ADDR_W    = 32;
  localparam int DEPTH_DEF = 4;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  // Default counter width; modules with a non-default depth use cnt_w().
  localparam int CNT_W = $clog2(DEPTH_DEF) + 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifid_queue_mem.sv
// DEPTH x W register array for the IF/ID queue.
// One synchronous write port, one asynchronous read port. Contents are not
// reset; the control logic never presents an unwritten entry as valid.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : combinational read data
module ifid_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifid_queue.sv
// DEPTH-entry instruction queue between IF and decode.
// Handshake: IF offers {Instruction_F, NPC_F} with push_valid; the entry is
// taken on the rising edge when push_valid & push_ready & ~kill. Decode takes
// the head on the rising edge when pop & ~empty & ~kill; pop on an empty queue
// is ignored. push_ready is combinational and may depend on pop, so a full
// queue still accepts a push in a cycle where decode pops.
// kill empties the queue on the next edge and discards any same-cycle push/pop.
// Ports:
//   clk, reset (async, active low)
//   push_valid/push_ready, Instruction_F, NPC_F : fetch side
//   pop, kill                                   : decode / hazard side
//   Instruction_D, NPC_D, valid_D               : head entry (NOP/0 when empty)
//   count, full, empty                          : occupancy status
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [INSTR_W-1:0] Instruction_F,
  input  logic [ADDR_W-1:0]  NPC_F,
  input  logic               pop,
  input  logic               kill,
  output logic [INSTR_W-1:0] Instruction_D,
  output logic [ADDR_W-1:0]  NPC_D,
  output logic               valid_D,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  localparam int W = INSTR_W + ADDR_W;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             push_en, pop_en;
  logic [W-1:0]     rdata;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  assign push_ready = ~full | (pop & ~kill);
  assign pop_en     = pop & ~empty & ~kill;
  assign push_en    = push_valid & push_ready & ~kill;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_en && !pop_en)      cnt_q <= cnt_q + CW'(1);
      else if (pop_en && !push_en) cnt_q <= cnt_q - CW'(1);
    end
  end

  ifid_queue_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk   (clk),
    .we    (push_en),
    .waddr (wr_ptr),
    .wdata ({Instruction_F, NPC_F}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign valid_D       = ~empty;
  assign Instruction_D = empty ? NOP_WORD : rdata[W-1:ADDR_W];
  assign NPC_D         = empty ? '0 : rdata[ADDR_W-1:0];

  // Occupancy must stay within 0..DEPTH; an underflow would wrap to a large value.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    cnt_q <= CW'(DEPTH));

endmodule

// File: tb/tb_ifid_queue.sv
module tb_ifid_queue;
  import ifid_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               push_valid = 1'b0;
  logic               push_ready;
  logic [INSTR_W-1:0] Instruction_F = '0;
  logic [ADDR_W-1:0]  NPC_F = '0;
  logic               pop = 1'b0;
  logic               kill = 1'b0;
  logic [INSTR_W-1:0] Instruction_D;
  logic [ADDR_W-1:0]  NPC_D;
  logic               valid_D;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;

  ifid_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .Instruction_F (Instruction_F),
    .NPC_F         (NPC_F),
    .pop           (pop),
    .kill          (kill),
    .Instruction_D (Instruction_D),
    .NPC_D         (NPC_D),
    .valid_D       (valid_D),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  // scoreboard: behavioural queue of {instr, npc}
  logic [INSTR_W+ADDR_W-1:0] exp_q[$];
  logic [INSTR_W-1:0]        popped[$];
  int vectors = 0;
  int errors  = 0;
  event chk_ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: DUT outputs against the model every cycle
  always @(chk_ev) begin
    logic [INSTR_W-1:0] e_ins;
    logic [ADDR_W-1:0]  e_npc;
    logic               e_rdy;
    e_ins = (exp_q.size() > 0) ? exp_q[0][INSTR_W+ADDR_W-1:ADDR_W] : NOP_WORD;
    e_npc = (exp_q.size() > 0) ? exp_q[0][ADDR_W-1:0] : '0;
    e_rdy = (exp_q.size() < DEPTH) || (pop && !kill);
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("Instruction_D", 64'(Instruction_D), 64'(e_ins));
    chk("NPC_D", 64'(NPC_D), 64'(e_npc));
    chk("valid_D", 64'(valid_D), 64'(exp_q.size() > 0));
    chk("full", 64'(full), 64'(exp_q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(exp_q.size() == 0));
    chk("push_ready", 64'(push_ready), 64'(e_rdy));
  end

  // driver: apply one cycle of inputs, check, clock, update model
  task automatic drive(input logic pv, input logic [31:0] ins, input logic [31:0] npc,
                       input logic p, input logic k);
    logic rdy;
    push_valid = pv; Instruction_F = ins; NPC_F = npc; pop = p; kill = k;
    #1;
    -> chk_ev;
    if (p && !k && valid_D) popped.push_back(Instruction_D);
    rdy = (exp_q.size() < DEPTH) || (p && !k);
    @(posedge clk);
    if (k) exp_q.delete();
    else begin
      if (p && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pv && rdy) exp_q.push_back({ins, npc});
    end
    @(negedge clk);
  endtask

  task automatic idle_settle();
    push_valid = 1'b0; pop = 1'b0; kill = 1'b0;
    #1;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    #1 -> chk_ev;
    chk("reset_instr_lit", 64'(Instruction_D), 64'h0);
    chk("reset_ready_lit", 64'(push_ready), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: fill with A1..A4
    for (int n = 1; n <= 4; n++) begin
      drive(1'b1, 32'hA000_0000 + n, 32'(n), 1'b0, 1'b0);
      chk("t1_count_lit", 64'(count), 64'(n));
      chk("t1_head_lit", 64'(Instruction_D), 64'hA000_0001);
      chk("t1_npc_lit", 64'(NPC_D), 64'h1);
    end
    idle_settle();
    chk("t1_full_lit", 64'(full), 64'h1);
    chk("t1_ready_lit", 64'(push_ready), 64'h0);
    drive(1'b1, 32'hEEEE_EEEE, 32'hEE, 1'b0, 1'b0); // refused push

    // 2: push while full with pop
    popped.delete();
    drive(1'b1, 32'hB000_0005, 32'd5, 1'b1, 1'b0);
    chk("t2_count_lit", 64'(count), 64'h4);
    chk("t2_head_lit", 64'(Instruction_D), 64'hA000_0002);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_order0", 64'(popped[0]), 64'hA000_0001);
    chk("t2_order1", 64'(popped[1]), 64'hA000_0002);
    chk("t2_order2", 64'(popped[2]), 64'hA000_0003);
    chk("t2_order3", 64'(popped[3]), 64'hA000_0004);
    chk("t2_order4", 64'(popped[4]), 64'hB000_0005);

    // 3: pop on empty
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t3_count_lit", 64'(count), 64'h0);
    chk("t3_instr_lit", 64'(Instruction_D), 64'h0);
    drive(1'b1, 32'h1234_5678, 32'h40, 1'b0, 1'b0);
    chk("t3_ptr_head_lit", 64'(Instruction_D), 64'h1234_5678);
    drive(1'b0, '0, '0, 1'b1, 1'b0);

    // 4: kill with two entries plus simultaneous push/pop
    drive(1'b1, 32'hD000_0001, 32'd1, 1'b0, 1'b0);
    drive(1'b1, 32'hD000_0002, 32'd2, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 32'd3, 1'b1, 1'b1);
    chk("t4_count_lit", 64'(count), 64'h0);
    chk("t4_instr_lit", 64'(Instruction_D), 64'h0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'hD000_0010, 32'd16, 1'b0, 1'b1); // kill held
    chk("t4_held_lit", 64'(empty), 64'h1);
    drive(1'b1, 32'hD000_0011, 32'd17, 1'b0, 1'b0);
    chk("t4_after_lit", 64'(Instruction_D), 64'hD000_0011);
    drive(1'b0, '0, '0, 1'b1, 1'b0);

    // 5: wrap-around streaming C0..C9
    popped.delete();
    for (int i = 0; i < 10; i++) drive(1'b1, 32'hC000_0000 + i, 32'(i), 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t5_npop", 64'(popped.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      if (i < popped.size()) chk("t5_order", 64'(popped[i]), 64'hC000_0000 + 64'(i));

    // 6: async reset mid-stream with three entries
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hF000_0000 + i, 32'(i), 1'b0, 1'b0);
    idle_settle();
    chk("t6_pre_count_lit", 64'(count), 64'h3);
    #1 reset = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_async_count_lit", 64'(count), 64'h0);
    chk("t6_async_empty_lit", 64'(empty), 64'h1);
    -> chk_ev;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h9999_0001, 32'h77, 1'b0, 1'b0);
    chk("t6_first_push_lit", 64'(Instruction_D), 64'h9999_0001);
    chk("t6_first_npc_lit", 64'(NPC_D), 64'h77);
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
